// File: rtl/chs_conf_receiver_if.sv
// Handshake/data bundle between a serial config source and chs_conf_receiver.
interface chs_conf_receiver_if;
    logic       start;
    logic       bit_valid;
    logic       inBit;
    logic [7:0] chs_conf;
    logic [3:0] ones_count;
    logic       isEven;
    logic       conf_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output start, bit_valid, inBit,
        input  chs_conf, ones_count, isEven,
        input  conf_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  start, bit_valid, inBit,
        output chs_conf, ones_count, isEven,
        output conf_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/chs_conf_receiver.sv
// Serial config-byte receiver, MSB first, with a 15-cycle bit timeout.
// Define CHS_PARITY_RX_EN for a trailing parity bit (1 when data has even ones).
module chs_conf_receiver (
    input logic                clk,
    input logic                rst,
    chs_conf_receiver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;

    state_t     state_q;
    logic [7:0] shift_q;
    logic [2:0] idx_q;
    logic [3:0] tally_q;
    logic [3:0] tmo_q;
    logic [7:0] conf_q;
    logic [3:0] ones_q;
    logic       even_q;
    logic       cv_q;
    logic       ferr_q;
`ifdef CHS_PARITY_RX_EN
    logic       perr_q;
`endif

    logic [7:0] shift_d;
    logic [3:0] tally_d;
    logic       busy;

    assign shift_d = {shift_q[6:0], bus.inBit};
    assign tally_d = (tally_q == 4'd8) ? tally_q
                   : tally_q + {3'b000, bus.inBit};
    assign busy    = (state_q == DATA) || (state_q == PARITY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= 8'h00;
            idx_q   <= 3'd0;
            tally_q <= 4'd0;
            tmo_q   <= 4'd0;
            conf_q  <= 8'h00;
            ones_q  <= 4'd0;
            even_q  <= 1'b1;
            cv_q    <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef CHS_PARITY_RX_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            cv_q   <= 1'b0;
            ferr_q <= 1'b0;
`ifdef CHS_PARITY_RX_EN
            perr_q <= 1'b0;
`endif
            // start wins over bit_valid in IDLE, DATA and PARITY
            if (bus.start && state_q != DONE) begin
                state_q <= DATA;
                shift_q <= 8'h00;
                idx_q   <= 3'd0;
                tally_q <= 4'd0;
                tmo_q   <= 4'd0;
            end else begin
                case (state_q)
                    IDLE: state_q <= IDLE;
                    DATA: begin
                        if (bus.bit_valid) begin
                            shift_q <= shift_d;
                            tally_q <= tally_d;
                            tmo_q   <= 4'd0;
                            idx_q   <= idx_q + 3'd1;
                            if (idx_q == 3'd7) begin
`ifdef CHS_PARITY_RX_EN
                                state_q <= PARITY;
`else
                                state_q <= DONE;
                                conf_q  <= shift_d;
                                ones_q  <= tally_d;
                                even_q  <= ~tally_d[0];
                                cv_q    <= 1'b1;
`endif
                            end
                        end else if (tmo_q == 4'd14) begin
                            state_q <= IDLE;
                            tmo_q   <= 4'd0;
                            ferr_q  <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 4'd1;
                        end
                    end
`ifdef CHS_PARITY_RX_EN
                    PARITY: begin
                        if (bus.bit_valid) begin
                            tmo_q <= 4'd0;
                            if (bus.inBit == ~tally_q[0]) begin
                                state_q <= DONE;
                                conf_q  <= shift_q;
                                ones_q  <= tally_q;
                                even_q  <= ~tally_q[0];
                                cv_q    <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                perr_q  <= 1'b1;
                            end
                        end else if (tmo_q == 4'd14) begin
                            state_q <= IDLE;
                            tmo_q   <= 4'd0;
                            ferr_q  <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 4'd1;
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.chs_conf   = conf_q;
    assign bus.ones_count = ones_q;
    assign bus.isEven     = even_q;
    assign bus.conf_valid = cv_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = busy;
`ifdef CHS_PARITY_RX_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: doc/chs_conf_receiver.md
CHS_CONF_RECEIVER -- requirements
Module: chs_conf_receiver

Interface
REQ-001 SHALL have a single clock domain and a synchronous, active-high reset.
REQ-002 SHALL expose these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame-start strobe, one cycle
- bit_valid  in  1  inBit is qualified this cycle
- inBit  in  1  serial data bit
- chs_conf  out  8  last accepted configuration byte
- ones_count  out  4  number of 1s in chs_conf, 0..8
- isEven  out  1  1 when ones_count is even
- conf_valid  out  1  one-cycle pulse: new frame accepted
- parity_err  out  1  one-cycle pulse: frame rejected, parity mismatch
- frame_err  out  1  one-cycle pulse: frame aborted, bit timeout
- busy  out  1  frame reception in progress

Function
REQ-003 SHALL implement FSM states IDLE, DATA, PARITY, DONE.
REQ-004 IDLE: busy=0; on start, go to DATA with bit index 0, shift register cleared, timeout counter cleared.
REQ-005 DATA: each bit_valid cycle shifts inBit in MSB first (first bit becomes chs_conf[7]). After the 8th bit, go to PARITY (parity enabled) or DONE (parity disabled).
REQ-006 DATA: a running ones tally SHALL increment by inBit on each accepted bit. The tally is 4 bits wide and SHALL never wrap (maximum 8).
REQ-007 PARITY: on bit_valid, expected bit = 1 if tally is even, else 0. On match go to DONE; on mismatch pulse parity_err and return to IDLE.
REQ-008 DONE: one cycle; update chs_conf/ones_count/isEven from the shift register and tally; pulse conf_valid in that same cycle; return to IDLE.
REQ-009 Frame latency: conf_valid SHALL assert on the cycle after the cycle that accepts the final bit.
REQ-010 chs_conf, ones_count and isEven SHALL change only in DONE. A rejected or aborted frame SHALL leave them unchanged.
REQ-011 busy=1 in DATA and PARITY.
REQ-012 Timeout: in DATA or PARITY, a 4-bit counter counts consecutive cycles without bit_valid.
- Reaching 15 pulses frame_err and returns to IDLE.
- Any bit_valid clears the counter.
REQ-013 start while busy SHALL restart the frame: clear index, tally, shift register and timeout. bit_valid in that same cycle SHALL be ignored.
REQ-014 start together with bit_valid in IDLE SHALL enter DATA without consuming the bit.
REQ-015 bit_valid in IDLE or DONE SHALL be ignored.
REQ-016 At most one of conf_valid, parity_err and frame_err SHALL be high in any cycle.

Reset
REQ-017 rst SHALL force IDLE and take priority over all other inputs, including in mid-frame.
REQ-018 After reset: chs_conf=8'h00, ones_count=0, isEven=1, conf_valid=0, parity_err=0, frame_err=0, busy=0, and all internal counters are 0.

Configuration
REQ-019 Macro CHS_PARITY_RX_EN:
- Defined: 9-bit frame (8 data bits then 1 parity bit), checked per REQ-007.
- Undefined: 8-bit frame, PARITY state absent, parity_err tied to 0.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Parity enabled, start then bits of 8'hA5 MSB first, then parity 1 -> next cycle conf_valid=1, chs_conf=8'hA5, ones_count=4, isEven=1.
- Parity enabled, 8'h07 then parity 1 -> parity_err pulse, chs_conf unchanged, FSM returns to IDLE.
- 3 data bits, then 15 idle cycles -> frame_err pulse on the 15th cycle, busy=0 the following cycle.
- rst asserted after 5 bits -> all outputs at reset values. A following full frame of 8'hFF with parity 1 -> ones_count=8, isEven=1.
- start re-asserted after 4 bits, then full frame 8'h3C -> only 8'h3C delivered, ones_count=4.
- Parity disabled, 8'h80 with bit_valid gaps of 2 cycles -> conf_valid, ones_count=1, isEven=0, parity_err never asserted.
